// File: rtl/nm_mem_resp.sv
// Latency-configurable word memory responder on a shared tri-state data bus.
// A request is latched in IDLE, timed out in WAIT and held as ready in RESP until the initiator lets go.
module nm_mem_resp #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_sel,
  input  logic                     mem_w,
  input  logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  output logic                     ready,
  output logic                     busy,
  output logic                     err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                   state, state_next;
  logic [3:0]               cnt, cnt_next;
  logic                     ready_next, err_next;
  logic                     load, fire, in_range;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     w_q;
  logic [DATABUS_WIDTH-1:0] wdata_q;
  logic [DATABUS_WIDTH-1:0] rdata;
  logic [DATABUS_WIDTH-1:0] mem [DEPTH];

  assign in_range = ({1'b0, addr_q} < DEPTH_W);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready_next = ready;
    err_next   = err;
    load       = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (mem_sel) begin
          load       = 1'b1;
          cnt_next   = mem_w ? WR_LOAD : RD_LOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        // Abort takes priority, so a dropped select never commits a write.
        if (!mem_sel) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_next = RESP;
          ready_next = 1'b1;
          fire       = 1'b1;
          if (!in_range) err_next = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (!mem_sel) begin
          state_next = IDLE;
          ready_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= ready_next;
      err   <= err_next;
    end
  end

  // Storage and request latches carry no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_q <= address_bus;
      w_q    <= mem_w;
      if (mem_w) wdata_q <= data_bus;
    end
    if (fire && w_q && in_range) mem[addr_q[IDX_W-1:0]] <= wdata_q;
    if (fire && !w_q) rdata <= in_range ? mem[addr_q[IDX_W-1:0]] : '0;
  end

  assign busy     = (state != IDLE);
  assign data_bus = (state == RESP && !w_q && mem_sel) ? rdata : 'z;

endmodule

// File: tb/tb_nm_mem_resp.sv
// Scoreboard bench for nm_mem_resp: default-latency instance plus a READ_LATENCY=4 instance for abort.
module tb_nm_mem_resp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_sel, mem_w;
  logic [15:0] address_bus;
  wire  [31:0] data_bus;
  logic [31:0] drv;
  logic        drv_en;
  logic        ready, busy, err;
  assign data_bus = drv_en ? drv : 'z;

  logic        sel4, w4;
  logic [15:0] addr4;
  wire  [31:0] bus4;
  logic [31:0] drv4;
  logic        drv4_en;
  logic        ready4, busy4, err4;
  assign bus4 = drv4_en ? drv4 : 'z;

  nm_mem_resp u_dut (
    .clk(clk), .rst(rst), .mem_sel(mem_sel), .mem_w(mem_w),
    .address_bus(address_bus), .data_bus(data_bus),
    .ready(ready), .busy(busy), .err(err)
  );

  nm_mem_resp #(.READ_LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .mem_sel(sel4), .mem_w(w4),
    .address_bus(addr4), .data_bus(bus4),
    .ready(ready4), .busy(busy4), .err(err4)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model [1024];
  logic        err_exp;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full handshake on u_dut; inputs are scrambled right after the sampling edge.
  task automatic request(input logic w, input logic [15:0] addr, input logic [31:0] wdata, input int hold);
    int          edges;
    int          lat;
    logic        oor;
    logic [31:0] exp;
    lat = w ? 1 : 2;
    oor = (addr >= 16'd1024);
    exp = 32'h0;
    @(negedge clk);
    mem_sel = 1'b1; mem_w = w; address_bus = addr; drv = wdata; drv_en = w;
    if (!oor) begin
      if (w) model[addr[9:0]] = wdata;
      else exp_q.push_back(model[addr[9:0]]);
    end else if (!w) begin
      exp_q.push_back(32'h0);
    end
    @(posedge clk);
    #1;
    address_bus = addr ^ 16'h0001; mem_w = ~w; drv = ~wdata;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!ready && edges < 20);
    check("latency", 32'(edges), 32'(lat));
    check("busy_resp", {31'b0, busy}, 32'd1);
    if (oor) err_exp = 1'b1;
    check("err", {31'b0, err}, {31'b0, err_exp});
    if (!w) begin
      exp = exp_q.pop_front();
      check("rdata", data_bus, exp);
    end
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("ready_hold", {31'b0, ready}, 32'd1);
      if (!w) check("rdata_hold", data_bus, exp);
    end
    mem_sel = 1'b0; drv_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_clr", {31'b0, ready}, 32'd0);
    check("busy_clr", {31'b0, busy}, 32'd0);
    if (!w && exp != 32'h0) check("bus_released", {31'b0, data_bus === exp}, 32'd0);
    $display("req w=%0b addr=%0d edges=%0d data=%h", w, addr, edges, w ? wdata : exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   edges;
    logic seen;
    rst = 1'b1; mem_sel = 1'b0; mem_w = 1'b0; address_bus = '0; drv = '0; drv_en = 1'b0;
    sel4 = 1'b0; w4 = 1'b0; addr4 = '0; drv4 = '0; drv4_en = 1'b0;
    err_exp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_busy4", {31'b0, busy4}, 32'd0);
    rst = 1'b0;

    // Stall pattern: writes then reads over addresses 0..7.
    for (int i = 0; i < 8; i++) request(1'b1, 16'(i), 32'hA000_0000 + 32'(i * 32'h0101_0101), 1);
    for (int i = 0; i < 8; i++) request(1'b0, 16'(i), 32'h0, 1);

    request(1'b1, 16'd5, 32'hDEADBEEF, 1);
    request(1'b0, 16'd5, 32'h0, 1);
    request(1'b1, 16'd7, 32'h12345678, 2);
    request(1'b0, 16'd7, 32'h0, 1);
    request(1'b0, 16'd4, 32'h0, 1);
    request(1'b0, 16'd6, 32'h0, 1);

    // Out-of-range: 1024 would alias to word 0 if its write leaked through.
    request(1'b1, 16'd1024, 32'hFFFFFFFF, 1);
    request(1'b0, 16'd1024, 32'h0, 1);
    request(1'b0, 16'd0, 32'h0, 1);

    // Async reset in the middle of a write's WAIT.
    request(1'b1, 16'd9, 32'h11111111, 1);
    @(negedge clk);
    mem_sel = 1'b1; mem_w = 1'b1; address_bus = 16'd9; drv = 32'hA5A5A5A5; drv_en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", {31'b0, ready}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_err", {31'b0, err}, 32'd0);
    err_exp = 1'b0;
    @(negedge clk);
    mem_sel = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    request(1'b0, 16'd9, 32'h0, 1);

    // Abort on the READ_LATENCY=4 instance.
    @(negedge clk);
    sel4 = 1'b1; w4 = 1'b1; addr4 = 16'd3; drv4 = 32'hCAFEF00D; drv4_en = 1'b1;
    @(posedge clk);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!ready4 && edges < 20);
    check("lat4_write", 32'(edges), 32'd1);
    sel4 = 1'b0; drv4_en = 1'b0;
    @(negedge clk);
    sel4 = 1'b1; w4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sel4 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (ready4) seen = 1'b1;
    end
    check("abort_ready", {31'b0, seen}, 32'd0);
    check("abort_busy", {31'b0, busy4}, 32'd0);
    $display("abort4 addr=3 ready_seen=%0b", seen);
    sel4 = 1'b1; w4 = 1'b0; addr4 = 16'd3;
    @(posedge clk);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!ready4 && edges < 20);
    check("lat4_read", 32'(edges), 32'd4);
    check("rdata4", bus4, 32'hCAFEF00D);
    check("err4", {31'b0, err4}, 32'd0);
    $display("req4 w=0 addr=3 edges=%0d data=%h", edges, bus4);
    sel4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready4_clr", {31'b0, ready4}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nm_mem_resp.md
NM_MEM_RESP -- requirements
Module: nm_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, address bus width.
REQ-002 SHALL have parameter DATABUS_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words stored (addresses 0..DEPTH-1).
REQ-004 SHALL have parameter READ_LATENCY, default 2, cycles from request sample to ready on read (legal range 1..15).
REQ-005 SHALL have parameter WRITE_LATENCY, default 1, cycles from request sample to ready on write (legal range 1..15).
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port mem_sel, input, 1, initiator request select.
REQ-009 SHALL have port mem_w, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port address_bus, input, ADDR_WIDTH, word address.
REQ-011 SHALL have port data_bus, inout, DATABUS_WIDTH, shared data bus.
REQ-012 SHALL have port ready, output, 1, request serviced.
REQ-013 SHALL have port busy, output, 1, high in WAIT or RESP.
REQ-014 SHALL have port err, output, 1, sticky out-of-range flag.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP.
REQ-016 IDLE: on an edge sampling mem_sel=1, SHALL latch address_bus, mem_w and (if write) data_bus, load counter with the latency minus 1 and go to WAIT.
REQ-017 WAIT: counter SHALL decrement each edge; on the edge where counter is 0 it SHALL go to RESP and register ready=1, giving ready high exactly L edges after the sampling edge (L = READ_LATENCY or WRITE_LATENCY).
REQ-018 Write commit SHALL occur on the WAIT->RESP edge, exactly once per request, using the latched address/data.
REQ-019 Read data SHALL be registered from the latched address on the WAIT->RESP edge.
REQ-020 data_bus SHALL be driven with read data only while state=RESP, latched mem_w=0 and mem_sel=1; otherwise it SHALL be high-impedance.
REQ-021 RESP: ready SHALL stay 1 until an edge samples mem_sel=0; that edge SHALL clear ready and return to IDLE.
REQ-022 Changes on address_bus, mem_w or data_bus after the sampling edge SHALL be ignored until the next IDLE.
REQ-023 Abort: mem_sel sampled 0 in WAIT SHALL return to IDLE with no write commit, no ready and no bus drive.
REQ-024 A new request SHALL be accepted on the first edge after returning to IDLE; back-to-back requests thus need mem_sel low for at least one edge.
REQ-025 Out-of-range (latched address >= DEPTH): reads SHALL return all zeros, writes SHALL be dropped, ready SHALL still follow REQ-017, and err SHALL set on the WAIT->RESP edge and stay set until reset.
REQ-026 busy SHALL be 1 exactly when state is WAIT or RESP.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, ready=0, busy=0, err=0, counter=0, and release data_bus to high-impedance.
REQ-028 Reset mid-request SHALL abort it with no write commit; storage contents SHALL be unaffected by reset.

Verification
REQ-029 Read, default latencies: preload word 5 = 0xDEADBEEF; mem_sel=1, mem_w=0, addr=5 sampled at edge N -> ready=1 and data_bus=0xDEADBEEF after edge N+2; deassert mem_sel at edge N+4 -> ready=0, bus Z.
REQ-030 Write then read: write 0x12345678 to addr 7 (ready after edge N+1, mem_sel held 2 more edges); then read addr 7 -> 0x12345678; an addr/data change during WAIT has no effect.
REQ-031 Controller stall pattern: mem_sel held 2 edges with ready high, then low 1 edge, repeated for addresses 0..7 -> 8 correct reads, one commit per write request, no duplicate commits.
REQ-032 Abort: READ_LATENCY=4, mem_sel dropped after 2 edges -> ready never 1, returns to IDLE, next request served normally.
REQ-033 Out-of-range: write 0xFFFFFFFF to addr 1024 -> ready asserted, err=1, no commit; read addr 1024 -> 0x00000000; err stays 1 until rst.
REQ-034 Async reset: assert rst between edges while in WAIT on a write -> ready=0, busy=0, bus Z immediately; target word keeps its old value.
